// File: rtl/pico_copy_master_if.sv
// Port-bus interface between the copy master and the system (Mem1 + output FIFO).
//   port_id      : port address driven by the master
//   out_port     : address or data driven by the master
//   write_strobe : one-cycle write pulse from the master
//   read_strobe  : read enable from the master
//   in_port      : read data returned by the system
//   fifo_full    : FIFO back-pressure from the system
interface pico_copy_master_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       fifo_full;

    modport master (
        output port_id,
        output out_port,
        output write_strobe,
        output read_strobe,
        input  in_port,
        input  fifo_full
    );

    modport slave (
        input  port_id,
        input  out_port,
        input  write_strobe,
        input  read_strobe,
        output in_port,
        output fifo_full
    );
endinterface

// File: rtl/pico_copy_master.sv
// Port-bus master that copies N_BYTES bytes from the memory port pair
// (address write on ADDR_PORT, data read on DATA_PORT) into the FIFO port.
//   clk, rst     : clock and synchronous active-high reset
//   start_i      : level, begins a transfer when sampled in IDLE or DONE
//   abort_i      : level, terminates a transfer in progress
//   bus          : port bus (port_id, out_port, strobes, in_port, fifo_full)
//   busy_o       : high while a transfer is in progress
//   done_o       : high from completion until the next start or reset
//   byte_cnt_o   : bytes written to the FIFO in the current or last transfer
module pico_copy_master #(
    parameter int unsigned N_BYTES   = 8,
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter int unsigned RD_WAIT   = 2,
    parameter logic [7:0]  ADDR_PORT = 8'h30,
    parameter logic [7:0]  DATA_PORT = 8'h31,
    parameter logic [7:0]  FIFO_PORT = 8'h20,
    parameter int unsigned CNT_W     = $clog2(N_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    pico_copy_master_if.master    bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_W-1:0]      byte_cnt_o
);

    localparam int unsigned IDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned WAIT_W = 4;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_BYTES - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_ADDR,
        S_RD_WAIT,
        S_CAPTURE,
        S_WRITE_FIFO,
        S_NEXT,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [7:0]          data_q;
    logic [7:0]          port_id_q;
    logic [7:0]          out_port_q;
    logic                write_strobe_q;
    logic                read_strobe_q;
    logic                busy_q;
    logic                done_q;
    logic [CNT_W-1:0]    byte_cnt_q;

    // Memory address of the current byte; 8-bit arithmetic wraps past FF.
    logic [7:0] mem_addr;
    assign mem_addr = BASE_ADDR + 8'(idx_q);

    // Transfer is in flight in every state except IDLE and DONE.
    logic in_xfer;
    assign in_xfer = (state_q != S_IDLE) && (state_q != S_DONE);

    // Transfer sequencer; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            wait_q         <= '0;
            data_q         <= '0;
            port_id_q      <= '0;
            out_port_q     <= '0;
            write_strobe_q <= 1'b0;
            read_strobe_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            byte_cnt_q     <= '0;
        end else if (abort_i && in_xfer) begin
            // Abort wins over stall and completion; byte count is kept.
            state_q        <= S_IDLE;
            write_strobe_q <= 1'b0;
            read_strobe_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    write_strobe_q <= 1'b0;
                    read_strobe_q  <= 1'b0;
                    if (start_i) begin
                        idx_q      <= '0;
                        byte_cnt_q <= '0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SET_ADDR;
                    end
                end
                S_SET_ADDR: begin
                    port_id_q      <= ADDR_PORT;
                    out_port_q     <= mem_addr;
                    write_strobe_q <= 1'b1;
                    wait_q         <= '0;
                    state_q        <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // One edge here per read_strobe cycle, RD_WAIT in total.
                    port_id_q      <= DATA_PORT;
                    read_strobe_q  <= 1'b1;
                    write_strobe_q <= 1'b0;
                    wait_q         <= wait_q + WAIT_W'(1);
                    if (wait_q == LAST_WAIT) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    data_q        <= bus.in_port;
                    read_strobe_q <= 1'b0;
                    state_q       <= S_WRITE_FIFO;
                end
                S_WRITE_FIFO: begin
                    if (bus.fifo_full) begin
                        write_strobe_q <= 1'b0;
                    end else begin
                        port_id_q      <= FIFO_PORT;
                        out_port_q     <= data_q;
                        write_strobe_q <= 1'b1;
                        byte_cnt_q     <= byte_cnt_q + CNT_W'(1);
                        state_q        <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    write_strobe_q <= 1'b0;
                    if (idx_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= S_SET_ADDR;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.port_id      = port_id_q;
    assign bus.out_port     = out_port_q;
    assign bus.write_strobe = write_strobe_q;
    assign bus.read_strobe  = read_strobe_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign byte_cnt_o       = byte_cnt_q;

endmodule

// File: doc/pico_copy_master.md
Name: pico_copy_master

Overview:
- Parametrised PicoBlaze-style port-bus master. It copies a block of N_BYTES bytes from the memory port pair (address port, data port) into the FIFO port.
- Next generation of the fixed 8-byte bring-up copier. Adds configurable port IDs, base address and read wait states, plus a start/abort handshake, FIFO back-pressure, restartable transfers and status outputs.
- Sits on the 8-bit port bus between the Mem1 read logic and the output FIFO, in place of a soft-core program.

Parameters:
N_BYTES     8       bytes per transfer, 1..256
BASE_ADDR   8'h00   memory address of the first byte
RD_WAIT     2       read_strobe cycles before capture, 1..15
ADDR_PORT   8'h30   port_id used for the memory-address write
DATA_PORT   8'h31   port_id used for the memory-data read
FIFO_PORT   8'h20   port_id used for the FIFO write
CNT_W       $clog2(N_BYTES+1)   width of byte_cnt

Ports:
clk           in   1      system clock, all logic on rising edge
rst           in   1      synchronous reset, active-high
start         in   1      level; sampled in IDLE or DONE to begin a transfer
abort         in   1      level; terminates a transfer in progress
fifo_full     in   1      FIFO cannot accept a write this cycle
in_port       in   8      read data from system (Mem1)
out_port      out  8      address or data driven to the bus
port_id       out  8      port address
write_strobe  out  1      one-cycle write pulse
read_strobe   out  1      read enable
busy          out  1      high while a transfer is in progress
done          out  1      high from transfer completion until next start or reset
byte_cnt      out  CNT_W  bytes written to the FIFO in the current or last transfer

Behaviour:
- Reset: one clock, synchronous, active-high (rst). Every output is 0 after the reset edge; state is IDLE; the internal index is 0.
- All outputs are registers. Each value appears in the cycle after the edge on which its state is processed.
- IDLE: busy=0, strobes 0. If start=1, clear index and byte_cnt, clear done, go to SET_ADDR.
- SET_ADDR: port_id<=ADDR_PORT, out_port<=(BASE_ADDR+index) mod 256, write_strobe<=1; go to RD_WAIT with wait counter=0.
- RD_WAIT: port_id<=DATA_PORT, read_strobe<=1. The wait counter increments; after RD_WAIT such edges go to CAPTURE. read_strobe is therefore high for exactly RD_WAIT consecutive cycles.
- CAPTURE: data_reg<=in_port, read_strobe<=0, port_id holds DATA_PORT; go to WRITE_FIFO.
- WRITE_FIFO: if fifo_full=1, stay and issue no strobe (stall, unbounded). Otherwise port_id<=FIFO_PORT, out_port<=data_reg, write_strobe<=1, byte_cnt+1; go to NEXT.
- NEXT:
  - if index==N_BYTES-1, go to DONE with done<=1 and busy<=0;
  - else index+1 and go to SET_ADDR.
- DONE: holds done=1 and busy=0. start=1 begins a new transfer exactly as from IDLE, and clears done in that edge.
- busy=1 in every state except IDLE and DONE.
- Unstalled byte period is RD_WAIT+4 cycles. An unstalled transfer therefore ends with done rising N_BYTES*(RD_WAIT+4) edges after the start-sampling edge (48 with defaults).
- Strobe rules:
  - write_strobe is never high for two consecutive cycles.
  - read_strobe and write_strobe are never high in the same cycle.
- Address arithmetic is 8-bit and wraps: BASE_ADDR=8'hFE, N_BYTES=4 gives FE, FF, 00, 01.
- abort=1 in any busy state forces IDLE on the next edge, with strobes 0, done=0 and byte_cnt held. abort takes priority over fifo_full and over completion in NEXT.
- start=1 while busy is ignored.
- rst mid-transfer returns to the reset state on that edge; no partial strobe follows.

Test Plan:
- Defaults, start pulse, fifo_full=0, memory[i]=8'hA0+i -> 8 address writes on 0x30 with out_port 00..07, then 8 FIFO writes on 0x20 with out_port A0..A7. done rises 48 cycles after start; byte_cnt=8.
- RD_WAIT=4 -> read_strobe high exactly 4 cycles per byte with port_id=0x31; byte period 8 cycles; data still captured correctly.
- fifo_full held high 10 cycles at byte 3 -> no strobe while full; write 0x20 with A3 issued the cycle after release; total latency +10 cycles.
- BASE_ADDR=8'hFE, N_BYTES=4 -> address writes FE, FF, 00, 01; done=1 and byte_cnt=4.
- abort asserted during RD_WAIT of byte 5 -> IDLE next cycle, strobes 0, done=0, byte_cnt=5. A new start then replays from address BASE_ADDR.
- From DONE, start again -> done drops in the same edge; a second full transfer runs. rst mid-transfer -> all outputs 0 the next cycle and state IDLE.
